mux2x32_arb: RTL and testbench

MUX2X32_ARB -- requirements
Module: mux2x32_arb

---
 rtl/mux2x32_arb.sv | 100 ++++++++++
 tb/tb_mux2x32_arb.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mux2x32_arb.sv
// mux2x32_arb: two valid/ready requesters share one registered output
// slot through a round-robin 2:1 select, with a transfer counter.
//
// Ports:
//   Clk, Clrn          clock, async active-low reset
//   A_valid/A_data     requester A offer, A_ready accept strobe
//   B_valid/B_data     requester B offer, B_ready accept strobe
//   Y_valid/Y_data     registered output word, Y_src 1=A 0=B
//   Y_ready            consumer accept
//   Cnt                completed output transfers (wraps)
module mux2x32_arb #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 16
) (
  input  logic             Clk,
  input  logic             Clrn,
  input  logic             A_valid,
  input  logic [WIDTH-1:0] A_data,
  output logic             A_ready,
  input  logic             B_valid,
  input  logic [WIDTH-1:0] B_data,
  output logic             B_ready,
  output logic             Y_valid,
  output logic [WIDTH-1:0] Y_data,
  output logic             Y_src,
  input  logic             Y_ready,
  output logic [CNTW-1:0]  Cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             src_q, src_d;
  logic             last_a_q, last_a_d;
  logic [CNTW-1:0]  cnt_q;
  logic             gnt_a, gnt_b;
  logic             free, accept, drain;

  // Tie goes to whoever was not served last.
  assign gnt_a = A_valid & (~B_valid | ~last_a_q);
  assign gnt_b = B_valid & (~A_valid | last_a_q);

  assign free    = (state_q == EMPTY) | Y_ready;
  assign A_ready = free & gnt_a;
  assign B_ready = free & gnt_b;
  // A grant already implies the matching valid.
  assign accept  = A_ready | B_ready;
  assign drain   = (state_q == FULL) & Y_ready;

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    src_d    = src_q;
    last_a_d = last_a_q;
    if (accept) begin
      data_d   = gnt_a ? A_data : B_data;
      src_d    = gnt_a;
      last_a_d = gnt_a;
    end
    unique case (state_q)
      EMPTY: if (accept) state_d = FULL;
      FULL: begin
        if (accept)       state_d = FULL;
        else if (Y_ready) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state_q  <= EMPTY;
      data_q   <= '0;
      src_q    <= 1'b0;
      last_a_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      src_q    <= src_d;
      last_a_q <= last_a_d;
    end
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn)
      cnt_q <= '0;
    else if (drain)
      cnt_q <= cnt_q + CNTW'(1);
  end

  assign Y_valid = (state_q == FULL);
  assign Y_data  = data_q;
  assign Y_src   = src_q;
  assign Cnt     = cnt_q;

endmodule

// File: tb/tb_mux2x32_arb.sv
// tb_mux2x32_arb: directed stimulus with a scoreboard queue;
// a negedge monitor pops and compares every drained output word.
module tb_mux2x32_arb;

  logic        Clk = 1'b0;
  logic        Clrn;
  logic        A_valid, B_valid, Y_ready;
  logic [31:0] A_data, B_data;
  logic        A_ready, B_ready, Y_valid, Y_src;
  logic [31:0] Y_data;
  logic [15:0] Cnt;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        src;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];

  mux2x32_arb #(.WIDTH(32), .CNTW(16)) dut (
    .Clk(Clk), .Clrn(Clrn),
    .A_valid(A_valid), .A_data(A_data), .A_ready(A_ready),
    .B_valid(B_valid), .B_data(B_data), .B_ready(B_ready),
    .Y_valid(Y_valid), .Y_data(Y_data), .Y_src(Y_src),
    .Y_ready(Y_ready), .Cnt(Cnt)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic src, input logic [31:0] d);
    exp_t e;
    e.src  = src;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Monitor: a word drains on the next rising edge.
  always @(negedge Clk) begin
    if (Clrn && Y_valid && Y_ready) begin
      exp_t e;
      if (sb.size() == 0) begin
        check("sb_unexpected_word", Y_data, 32'hxxxx_xxxx);
      end else begin
        e = sb.pop_front();
        check("sb_y_data", Y_data, e.data);
        check("sb_y_src", {31'b0, Y_src}, {31'b0, e.src});
      end
    end
  end

  initial begin
    Clrn = 1'b0;
    A_valid = 1'b0; B_valid = 1'b0; Y_ready = 1'b0;
    A_data = '0; B_data = '0;

    // Reset state
    @(negedge Clk);
    check("rst_y_valid", {31'b0, Y_valid}, 32'd0);
    check("rst_y_data", Y_data, 32'd0);
    check("rst_y_src", {31'b0, Y_src}, 32'd0);
    check("rst_cnt", {16'b0, Cnt}, 32'd0);

    // Single A transfer, first edge after release
    Clrn = 1'b1;
    A_valid = 1'b1; A_data = 32'h1111_1111; Y_ready = 1'b1;
    push(1'b1, 32'h1111_1111);
    #1;
    check("t1_a_ready", {31'b0, A_ready}, 32'd1);
    check("t1_b_ready", {31'b0, B_ready}, 32'd0);
    tick();
    A_valid = 1'b0;
    @(negedge Clk);
    check("t1_y_valid", {31'b0, Y_valid}, 32'd1);
    tick();
    @(negedge Clk);
    check("t1_cnt", {16'b0, Cnt}, 32'd1);
    check("t1_empty", {31'b0, Y_valid}, 32'd0);

    // One B word, then both valid: alternate A,B,A,B
    tick();
    B_valid = 1'b1; B_data = 32'h2222_2222;
    push(1'b0, 32'h2222_2222);
    tick();
    A_valid = 1'b1; A_data = 32'hAAAA_AAAA; B_data = 32'hBBBB_BBBB;
    push(1'b1, 32'hAAAA_AAAA);
    push(1'b0, 32'hBBBB_BBBB);
    push(1'b1, 32'hAAAA_AAAA);
    push(1'b0, 32'hBBBB_BBBB);
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      check("t2_one_ready", {30'b0, 2'(A_ready) + 2'(B_ready)}, 32'd1);
      tick();
    end
    A_valid = 1'b0; B_valid = 1'b0;
    tick();
    @(negedge Clk);
    check("t2_cnt", {16'b0, Cnt}, 32'd6);
    check("t2_empty", {31'b0, Y_valid}, 32'd0);

    // Backpressure: stall 5 cycles, then drain+accept together
    tick();
    Y_ready = 1'b0;
    A_valid = 1'b1; A_data = 32'h3333_3333;
    push(1'b1, 32'h3333_3333);
    tick();
    A_data = 32'h4444_4444;
    B_valid = 1'b1; B_data = 32'h5555_5555;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      check("t3_hold_data", Y_data, 32'h3333_3333);
      check("t3_hold_src", {31'b0, Y_src}, 32'd1);
      check("t3_hold_valid", {31'b0, Y_valid}, 32'd1);
      check("t3_no_ready", {30'b0, A_ready, B_ready}, 32'd0);
      tick();
    end
    Y_ready = 1'b1;
    push(1'b0, 32'h5555_5555);
    push(1'b1, 32'h4444_4444);
    @(negedge Clk);
    check("t3_b_ready", {31'b0, B_ready}, 32'd1);
    check("t3_a_ready", {31'b0, A_ready}, 32'd0);
    tick();
    B_valid = 1'b0;
    @(negedge Clk);
    check("t3_reload", Y_data, 32'h5555_5555);
    tick();
    A_valid = 1'b0;
    tick();
    @(negedge Clk);
    check("t3_cnt", {16'b0, Cnt}, 32'd9);
    check("t3_empty", {31'b0, Y_valid}, 32'd0);

    // Counter wrap: stream to 65535, one more gives 0
    tick();
    A_valid = 1'b1;
    for (int i = 0; i < 65526; i++) begin
      A_data = i;
      push(1'b1, i);
      tick();
    end
    A_valid = 1'b0;
    tick();
    @(negedge Clk);
    check("t4_cnt_max", {16'b0, Cnt}, 32'd65535);
    tick();
    A_valid = 1'b1; A_data = 32'h6666_6666;
    push(1'b1, 32'h6666_6666);
    tick();
    A_valid = 1'b0;
    tick();
    @(negedge Clk);
    check("t4_cnt_wrap", {16'b0, Cnt}, 32'd0);

    // Async reset with a held word, then A wins the first tie
    tick();
    Y_ready = 1'b0;
    A_valid = 1'b1; A_data = 32'h7777_7777;
    tick();
    A_valid = 1'b0;
    @(negedge Clk);
    check("t5_held", {31'b0, Y_valid}, 32'd1);
    #1;
    Clrn = 1'b0;
    #1;
    check("t5_rst_valid", {31'b0, Y_valid}, 32'd0);
    check("t5_rst_data", Y_data, 32'd0);
    check("t5_rst_cnt", {16'b0, Cnt}, 32'd0);
    A_valid = 1'b1; A_data = 32'h8888_8888;
    B_valid = 1'b1; B_data = 32'h9999_9999;
    #1;
    check("t5_rst_a_ready", {31'b0, A_ready}, 32'd1);
    check("t5_rst_b_ready", {31'b0, B_ready}, 32'd0);
    Clrn = 1'b1;
    Y_ready = 1'b1;
    push(1'b1, 32'h8888_8888);
    push(1'b0, 32'h9999_9999);
    tick();
    tick();
    A_valid = 1'b0; B_valid = 1'b0;
    tick();
    @(negedge Clk);
    check("t5_cnt", {16'b0, Cnt}, 32'd2);
    check("sb_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
